// File: rtl/uart_rx_cfg_if.sv
// Character hand-off between the configurable UART receiver and its consumer.
// Receiver side is master: it presents data and flags, the consumer answers with i_rdy.
interface uart_rx_cfg_if;
    logic       o_vld;
    logic       i_rdy;
    logic [7:0] o_dat;
    logic       o_par_err;
    logic       o_frm_err;
    logic       o_brk;
    logic       o_ovr_err;

    modport master (
        output o_vld, o_dat, o_par_err, o_frm_err, o_brk, o_ovr_err,
        input  i_rdy
    );

    modport slave (
        input  o_vld, o_dat, o_par_err, o_frm_err, o_brk, o_ovr_err,
        output i_rdy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, parity, 1/2 stop), 3-sample majority vote, break detect.
// Latency: start edge seen P_SYNC_STAGES+1 clocks after the line falls; o_vld the clock after the final vote tick.
// Backpressure: one-deep holding register; a character completing while it is full and not taken is dropped with o_ovr_err.
module uart_rx_cfg #(
    parameter int P_DIV_W       = 16,
    parameter int P_OVS         = 16,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_uart_rx,
    input  logic [P_DIV_W-1:0] i_cfg_div,
    input  logic [1:0]         i_cfg_dbits,
    input  logic [1:0]         i_cfg_parity,
    input  logic               i_cfg_stop2,
    uart_rx_cfg_if.master      rx_if,
    output logic               o_busy
);
    localparam int OW = $clog2(P_OVS);
    localparam int H  = P_OVS / 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BRK_WAIT
    } state_t;

    state_t                   state_q, state_d;
    logic [P_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                     prev_q, prev_d;
    logic [P_DIV_W-1:0]       div_cnt_q, div_cnt_d, cfg_div_q, cfg_div_d;
    logic [OW-1:0]            ovs_q, ovs_d;
    logic [1:0]               smp_q, smp_d, cfg_dbits_q, cfg_dbits_d, cfg_par_q, cfg_par_d;
    logic                     cfg_stop2_q, cfg_stop2_d;
    logic [2:0]               bit_q, bit_d;
    logic [7:0]               shr_q, shr_d, dat_q, dat_d;
    logic                     par_acc_q, par_acc_d, zero_q, zero_d;
    logic                     ferr_q, ferr_d, perr_q, perr_d;
    logic                     vld_q, vld_d, perr_o_q, perr_o_d, frm_q, frm_d;
    logic                     brk_q, brk_d, ovr_q, ovr_d, busy_q, busy_d;

    logic rx_s, tick, end_bit, vote_pt, vote, cmpl, cmpl_brk, par_en, par_odd;

    assign rx_s    = sync_q[P_SYNC_STAGES-1];
    assign par_en  = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);
    assign par_odd = (cfg_par_q == 2'b10);
    assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        state_d     = state_q;
        sync_d      = {sync_q[P_SYNC_STAGES-2:0], i_uart_rx};
        prev_d      = rx_s;
        div_cnt_d   = div_cnt_q;
        cfg_div_d   = cfg_div_q;
        cfg_dbits_d = cfg_dbits_q;
        cfg_par_d   = cfg_par_q;
        cfg_stop2_d = cfg_stop2_q;
        ovs_d       = ovs_q;
        smp_d       = smp_q;
        bit_d       = bit_q;
        shr_d       = shr_q;
        par_acc_d   = par_acc_q;
        zero_d      = zero_q;
        ferr_d      = ferr_q;
        perr_d      = perr_q;
        vld_d       = vld_q;
        dat_d       = dat_q;
        perr_o_d    = perr_o_q;
        frm_d       = frm_q;
        brk_d       = brk_q;
        ovr_d       = 1'b0;
        busy_d      = (state_q != S_IDLE);
        tick        = 1'b0;
        cmpl        = 1'b0;
        cmpl_brk    = 1'b0;

        if (state_q == S_IDLE) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == cfg_div_q) begin
            div_cnt_d = '0;
            tick      = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        end_bit = tick && (ovs_q == OW'(P_OVS - 1));
        vote_pt = tick && (ovs_q == OW'(H + 1));

        if (tick) begin
            ovs_d = end_bit ? '0 : ovs_q + 1'b1;
            if (ovs_q == OW'(H - 1)) smp_d[0] = rx_s;
            if (ovs_q == OW'(H))     smp_d[1] = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d     = S_START;
                    cfg_div_d   = i_cfg_div;
                    cfg_dbits_d = i_cfg_dbits;
                    cfg_par_d   = i_cfg_parity;
                    cfg_stop2_d = i_cfg_stop2;
                    div_cnt_d   = '0;
                    ovs_d       = '0;
                    bit_d       = '0;
                    shr_d       = '0;
                    par_acc_d   = 1'b0;
                    zero_d      = 1'b1;
                    ferr_d      = 1'b0;
                    perr_d      = 1'b0;
                end
            end
            S_START: begin
                if (vote_pt && vote) state_d = S_IDLE;
                else if (end_bit)    state_d = S_DATA;
            end
            S_DATA: begin
                if (vote_pt) begin
                    shr_d[bit_q] = vote;
                    par_acc_d    = par_acc_q ^ vote;
                    if (vote) zero_d = 1'b0;
                end
                if (end_bit) begin
                    if (bit_q == ({1'b0, cfg_dbits_q} + 3'd4)) state_d = par_en ? S_PARITY : S_STOP1;
                    else                                       bit_d   = bit_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (vote_pt) begin
                    perr_d = ((par_acc_q ^ vote) != par_odd);
                    if (vote) zero_d = 1'b0;
                end
                if (end_bit) state_d = S_STOP1;
            end
            S_STOP1: begin
                // Single-stop frames finish at the vote so a start edge right after the stop bit is caught.
                if (vote_pt) begin
                    ferr_d = ferr_q | ~vote;
                    if (zero_q && !vote) begin
                        cmpl     = 1'b1;
                        cmpl_brk = 1'b1;
                        state_d  = S_BRK_WAIT;
                    end else if (!cfg_stop2_q) begin
                        cmpl    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (end_bit) begin
                    state_d = S_STOP2;
                end
            end
            S_STOP2: begin
                if (vote_pt) begin
                    ferr_d  = ferr_q | ~vote;
                    cmpl    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BRK_WAIT: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cmpl) begin
            if (!vld_q || rx_if.i_rdy) begin
                vld_d    = 1'b1;
                dat_d    = cmpl_brk ? 8'h00 : shr_q;
                perr_o_d = perr_q;
                frm_d    = cmpl_brk | ferr_q | ~vote;
                brk_d    = cmpl_brk;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (vld_q && rx_if.i_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            prev_q      <= 1'b1;
            div_cnt_q   <= '0;
            cfg_div_q   <= '0;
            cfg_dbits_q <= '0;
            cfg_par_q   <= '0;
            cfg_stop2_q <= 1'b0;
            ovs_q       <= '0;
            smp_q       <= '0;
            bit_q       <= '0;
            shr_q       <= '0;
            par_acc_q   <= 1'b0;
            zero_q      <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            vld_q       <= 1'b0;
            dat_q       <= '0;
            perr_o_q    <= 1'b0;
            frm_q       <= 1'b0;
            brk_q       <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            div_cnt_q   <= div_cnt_d;
            cfg_div_q   <= cfg_div_d;
            cfg_dbits_q <= cfg_dbits_d;
            cfg_par_q   <= cfg_par_d;
            cfg_stop2_q <= cfg_stop2_d;
            ovs_q       <= ovs_d;
            smp_q       <= smp_d;
            bit_q       <= bit_d;
            shr_q       <= shr_d;
            par_acc_q   <= par_acc_d;
            zero_q      <= zero_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            vld_q       <= vld_d;
            dat_q       <= dat_d;
            perr_o_q    <= perr_o_d;
            frm_q       <= frm_d;
            brk_q       <= brk_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_if.o_vld     = vld_q;
    assign rx_if.o_dat     = dat_q;
    assign rx_if.o_par_err = perr_o_q;
    assign rx_if.o_frm_err = frm_q;
    assign rx_if.o_brk     = brk_q;
    assign rx_if.o_ovr_err = ovr_q;
    assign o_busy          = busy_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames plus randomized configurations checked against a frame-level model.
module tb_uart_rx_cfg;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] div = '0;
    logic [1:0]  dbits = 2'd3;
    logic [1:0]  par = 2'd0;
    logic        stop2 = 1'b0;
    logic        busy;

    uart_rx_cfg_if bus();

    uart_rx_cfg #(.P_DIV_W(16), .P_OVS(16), .P_SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_uart_rx   (rx),
        .i_cfg_div   (div),
        .i_cfg_dbits (dbits),
        .i_cfg_parity(par),
        .i_cfg_stop2 (stop2),
        .rx_if       (bus),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   rise_cnt = 0;
    int   ovr_cyc = 0;
    int   busy_cyc = 0;
    logic vld_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.o_vld && !vld_prev) rise_cnt++;
        vld_prev = bus.o_vld;
        if (bus.o_ovr_err) ovr_cyc++;
        if (busy) busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat ((int'(div) + 1) * 16) @(negedge clk);
    endtask

    task automatic tx_frame(input logic [7:0] d, input int nb, input logic pen, input logic pbit,
                            input logic s1, input logic has_s2, input logic s2b, input int idle_bits);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (pen) drive_bit(pbit);
        drive_bit(s1);
        if (has_s2) drive_bit(s2b);
        for (int i = 0; i < idle_bits; i++) drive_bit(1'b1);
    endtask

    // Character the receiver should report for a frame described by its fields.
    task automatic model(input logic [7:0] d, input logic [1:0] p, input logic pbit, input logic s1,
                         input logic s2, input logic s2b,
                         output logic [7:0] ed, output logic pe, output logic fe, output logic bk);
        logic pen, odd;
        pen = (p == 2'b01) || (p == 2'b10);
        odd = (p == 2'b10);
        ed  = d;
        pe  = pen && (((^d) ^ pbit) != odd);
        fe  = !s1 || (s2 && !s2b);
        bk  = (d == 8'h00) && (!pen || !pbit) && !s1;
        if (bk) begin
            ed = 8'h00;
            fe = 1'b1;
        end
    endtask

    task automatic expect_char(input string tag, input logic [7:0] d, input logic pe, input logic fe,
                               input logic bk, input int rises_before, input logic chk_pe);
        chk({tag, "_vld"}, 32'(bus.o_vld), 32'd1);
        chk({tag, "_nchar"}, 32'(rise_cnt - rises_before), 32'd1);
        chk({tag, "_dat"}, 32'(bus.o_dat), 32'(d));
        if (chk_pe) chk({tag, "_perr"}, 32'(bus.o_par_err), 32'(pe));
        chk({tag, "_ferr"}, 32'(bus.o_frm_err), 32'(fe));
        chk({tag, "_brk"}, 32'(bus.o_brk), 32'(bk));
    endtask

    task automatic ack(input string tag);
        bus.i_rdy = 1'b1;
        @(negedge clk);
        bus.i_rdy = 1'b0;
        chk({tag, "_drop"}, 32'(bus.o_vld), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, 32'(bus.o_vld), 32'd0);
        chk({tag, "_dat"}, 32'(bus.o_dat), 32'd0);
        chk({tag, "_flags"}, 32'({bus.o_par_err, bus.o_frm_err, bus.o_brk, bus.o_ovr_err}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int r, b, o, nb;
        logic [7:0] d, ed, mask;
        logic pen, pbit, s1, s2b, epe, efe, ebk;

        bus.i_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        r = rise_cnt;
        tx_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        expect_char("a5", 8'hA5, 1'b0, 1'b0, 1'b0, r, 1'b1);
        repeat (40) @(negedge clk);
        chk("a5_hold", 32'(bus.o_vld), 32'd1);
        ack("a5");

        dbits = 2'd2; par = 2'b01;
        r = rise_cnt;
        tx_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2);
        expect_char("7e1_bad", 8'h35, 1'b1, 1'b0, 1'b0, r, 1'b1);
        ack("7e1_bad");
        r = rise_cnt;
        tx_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        expect_char("7e1_ok", 8'h35, 1'b0, 1'b0, 1'b0, r, 1'b1);
        ack("7e1_ok");

        dbits = 2'd3; par = 2'b00; stop2 = 1'b1;
        r = rise_cnt;
        tx_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2);
        expect_char("8n2_bad", 8'h5A, 1'b0, 1'b1, 1'b0, r, 1'b1);
        ack("8n2_bad");
        r = rise_cnt;
        tx_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        expect_char("8n2_ok", 8'h5A, 1'b0, 1'b0, 1'b0, r, 1'b1);
        ack("8n2_ok");

        stop2 = 1'b0;
        r = rise_cnt; b = busy_cyc;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("fs_busy_seen", 32'(busy_cyc > b), 32'd1);
        chk("fs_busy_idle", 32'(busy), 32'd0);
        chk("fs_nchar", 32'(rise_cnt - r), 32'd0);
        r = rise_cnt;
        tx_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        expect_char("3c", 8'h3C, 1'b0, 1'b0, 1'b0, r, 1'b1);
        ack("3c");

        r = rise_cnt;
        for (int i = 0; i < 12; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        expect_char("brk", 8'h00, 1'b0, 1'b1, 1'b1, r, 1'b1);
        ack("brk");
        r = rise_cnt;
        tx_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        expect_char("c3", 8'hC3, 1'b0, 1'b0, 1'b0, r, 1'b1);
        ack("c3");

        for (int n = 0; n < 24; n++) begin
            div   = 16'($urandom_range(0, 2));
            dbits = 2'($urandom_range(0, 3));
            par   = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            nb    = int'(dbits) + 5;
            mask  = 8'((1 << nb) - 1);
            d     = 8'($urandom) & mask;
            if (n % 6 == 0) d = 8'h00;
            pen   = (par == 2'b01) || (par == 2'b10);
            pbit  = (^d) ^ (par == 2'b10);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            s1    = ($urandom_range(0, 7) != 0);
            s2b   = ($urandom_range(0, 7) != 0);
            if (n % 8 == 3) begin
                d = 8'h00; pbit = 1'b0; s1 = 1'b0;
            end
            model(d, par, pbit, s1, stop2, s2b, ed, epe, efe, ebk);
            r = rise_cnt;
            tx_frame(d, nb, pen, pbit, s1, stop2, s2b, 2);
            expect_char($sformatf("rnd%0d", n), ed, epe, efe, ebk, r, !ebk);
            ack($sformatf("rnd%0d", n));
        end

        div = '0; dbits = 2'd3; par = 2'b00; stop2 = 1'b0;
        r = rise_cnt; o = ovr_cyc;
        tx_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
        tx_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        chk("ovr_nchar", 32'(rise_cnt - r), 32'd1);
        chk("ovr_pulse", 32'(ovr_cyc - o), 32'd1);
        chk("ovr_dat", 32'(bus.o_dat), 32'h11);
        ack("ovr");

        r = rise_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (64) @(negedge clk);
        chk("post_rst_vld", 32'(bus.o_vld), 32'd0);
        chk("post_rst_nchar", 32'(rise_cnt - r), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver and successor to the fixed 8N1 receiver. It supports 5-8 data bits, none/even/odd parity, 1 or 2 stop bits, and a runtime baud divisor. Each bit is oversampled and decided by a 3-sample majority vote; the block also detects break. Received characters go into a valid/ready holding register with parity, framing, break and overrun flags, and the block sits between the board RX pin and the host-side command/AXI bridge logic.

Parameters:
P_DIV_W, 16, width of runtime tick divisor i_cfg_div
P_OVS, 16, oversample ticks per bit; legal values 8 or 16
P_SYNC_STAGES, 2, input synchronizer depth (>=2)

Ports:
clk  in  1  system clock (100MHz)
rstn  in  1  asynchronous reset, active low
i_uart_rx  in  1  serial line, asynchronous, idle high
i_cfg_div  in  P_DIV_W  tick period minus 1; one tick every i_cfg_div+1 clocks
i_cfg_dbits  in  2  data bits minus 5 (0=5 .. 3=8)
i_cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
i_cfg_stop2  in  1  1 = two stop bits
o_vld  out  1  holding register valid
i_rdy  in  1  consumer accepts when o_vld&i_rdy
o_dat  out  8  received data, right-aligned, unused upper bits 0
o_par_err  out  1  parity mismatch for held character
o_frm_err  out  1  a stop bit sampled 0 for held character
o_brk  out  1  held character is a break
o_ovr_err  out  1  one-cycle pulse: completed character dropped
o_busy  out  1  receiver not idle (registered)

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): state IDLE, synchronizer flops = 1, all counters 0. o_vld, o_dat, o_par_err, o_frm_err, o_brk, o_ovr_err and o_busy are all 0. Reset mid-frame aborts the frame with no output.
- Config: i_cfg_* latched on start detection. Changes mid-frame take effect on the next frame.
- Tick generator: counter 0..div, held at 0 in IDLE, cleared on start detection. div=0 gives a tick every clock.
- Ovs counter: 0..P_OVS-1 per bit, advanced on tick. Samples are taken at P_OVS/2-1, P_OVS/2 and P_OVS/2+1. The bit value is the 2-of-3 majority, resolved at the P_OVS/2+1 tick (the "vote point").
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, BRK_WAIT.
- IDLE: synchronized line 1->0 goes to START.
- START: vote=1 at the vote point is a false start: go to IDLE with no output. Otherwise go to DATA at the end of the bit (ovs=P_OVS-1 tick).
- DATA: shift LSB first, dbits+5 bits. Go to PARITY if parity is enabled, else STOP1.
- PARITY: par_err = (xor of data bits ^ parity bit) != odd.
- STOP1: frm_err |= ~vote. If stop2, go to STOP2 at the end of the bit. Otherwise the frame completes at this vote point; the half bit is skipped so the next start edge is not missed.
- STOP2: frm_err |= ~vote; the frame completes at this vote point.
- Break condition: all data bits 0, parity bit 0 (if present) and STOP1 vote 0. Frame completes with o_brk=1, o_frm_err=1, o_dat=0, then go to BRK_WAIT.
- BRK_WAIT: stay until the synchronized line is 1, then IDLE. Exactly one character is reported per break regardless of its length.
- All other completions go to IDLE.
- Completion writes the holding register; o_vld rises the clock after the completing vote tick. Flags change only when o_dat is loaded.
- Holding register behaviour:
  - o_vld&i_rdy without completion: o_vld is cleared.
  - Completion with o_vld=0, or with o_vld&i_rdy in the same cycle: load the new character; o_vld stays/goes 1.
  - Completion with o_vld&~i_rdy: the new character is dropped, the holding register is unchanged, and o_ovr_err pulses 1 cycle.
- o_busy = registered (state != IDLE); lags state by 1 clock.
- Line-to-edge latency: P_SYNC_STAGES+1 clocks.

Test Plan:
- div=0, P_OVS=16 (16 clk/bit), 8N1, send 0xA5, i_rdy=0 -> o_dat=0xA5, all flags 0. o_vld stays 1 until an i_rdy pulse, then drops the next clock.
- 7E1, send 0x35 with parity bit 1 (correct is 0) -> o_dat=0x35, o_par_err=1. Then send 0x35 with parity 0 -> o_par_err=0.
- 8N2, send 0x5A with second stop bit driven 0 -> o_dat=0x5A, o_frm_err=1. Repeat with both stops 1 -> o_frm_err=0.
- Line low for 4 clocks then high -> no o_vld; o_busy pulses then returns 0. A following 0x3C frame is received correctly.
- 8N1, line held low for 12 bit times then high -> a single o_vld with o_dat=0x00, o_brk=1, o_frm_err=1. The next 0xC3 is received normally after the line returns high.
- Overrun and reset:
  - Frames 0x11 then 0x22 back-to-back with i_rdy=0 -> o_dat stays 0x11 and o_ovr_err pulses 1 clock.
  - Then assert rstn=0 mid-frame -> all outputs 0 immediately, and no o_vld after release.
